// File: rtl/non_max_suppression_pkg.sv
// Shared image constants and enums for the Canny non-maximum-suppression stage.
package non_max_suppression_pkg;

  localparam int WIDTH       = 720;
  localparam int HEIGHT      = 540;
  localparam int PIXEL_COUNT = WIDTH * HEIGHT;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;

  typedef enum logic [1:0] {PROLOGUE, NMS, OUTPUT} state_t;

endpackage

// File: rtl/non_max_suppression_compare.sv
// Direction-selected local-maximum test for one 3x3 window.
// NMS_STRICT_EN: keep the centre only when strictly above both neighbours.
module nms_compare
  import non_max_suppression_pkg::*;
(
  input  logic [7:0]  centre,
  input  logic [31:0] neighbour_a,  // byte n = first neighbour for direction n
  input  logic [31:0] neighbour_b,  // byte n = opposite neighbour for direction n
  input  logic [1:0]  direction,
  output logic [7:0]  result
);

  logic [7:0] mag_a;
  logic [7:0] mag_b;
  logic       keep;

  always_comb begin
    mag_a = neighbour_a[7:0];
    mag_b = neighbour_b[7:0];
    case (dir_t'(direction))
      DIR_45: begin
        mag_a = neighbour_a[15:8];
        mag_b = neighbour_b[15:8];
      end
      DIR_90: begin
        mag_a = neighbour_a[23:16];
        mag_b = neighbour_b[23:16];
      end
      DIR_135: begin
        mag_a = neighbour_a[31:24];
        mag_b = neighbour_b[31:24];
      end
      default: ;
    endcase
  end

`ifdef NMS_STRICT_EN
  assign keep = (centre > mag_a) && (centre > mag_b);
`else
  assign keep = (centre >= mag_a) && (centre >= mag_b);
`endif

  assign result = keep ? centre : 8'd0;

endmodule

// File: rtl/non_max_suppression.sv
// Non-maximum suppression over a two-line window fed from the Sobel FIFO, one push per pixel.
// NMS_STRICT_EN (in nms_compare) turns ties into suppression.
module non_max_suppression #(
  parameter int WIDTH  = non_max_suppression_pkg::WIDTH,
  parameter int HEIGHT = non_max_suppression_pkg::HEIGHT
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [9:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);
  import non_max_suppression_pkg::*;

  localparam int DEPTH        = 2 * WIDTH + 3;
  localparam int CTR          = WIDTH + 1;
  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int PAD_START    = FRAME_PIXELS - 1 - (WIDTH + 2);
  localparam int COL_W        = $clog2(WIDTH);
  localparam int ROW_W        = $clog2(HEIGHT);
  localparam int CNT_W        = $clog2(WIDTH + 3);
  localparam int POS_W        = $clog2(FRAME_PIXELS);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [7:0]       result_reg, result_next;

  logic [9:0]       sr_q [DEPTH];
  logic [9:0]       shift_word;
  logic [POS_W-1:0] pos;
  logic             pad_region, shift, pop, border, last_pixel;
  logic [31:0]      nbr_a, nbr_b;
  logic [7:0]       cmp_result;

  // Index 0 is the oldest word; new words enter at DEPTH-1.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_line
      logic [9:0] word_reg;
      logic [9:0] feed;
      if (gi == DEPTH - 1) begin : g_top
        assign feed = shift_word;
      end else begin : g_mid
        assign feed = sr_q[gi + 1];
      end
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          word_reg <= '0;
        end else if (shift) begin
          word_reg <= feed;
        end
      end
      assign sr_q[gi] = word_reg;
    end
  endgenerate

  assign pos        = POS_W'(row_reg) * POS_W'(WIDTH) + POS_W'(col_reg);
  // Past the last real word the window is completed with zeros; any waiting word
  // belongs to the next frame and is left in the FIFO.
  assign pad_region = (state_reg == NMS) && (pos > POS_W'(PAD_START));
  assign shift      = (state_reg != OUTPUT) && (pad_region || !in_empty);
  assign pop        = (state_reg != OUTPUT) && !pad_region && !in_empty;
  assign shift_word = pop ? in_dout : '0;

  assign border     = (row_reg == '0) || (row_reg == ROW_W'(HEIGHT - 1)) ||
                      (col_reg == '0) || (col_reg == COL_W'(WIDTH - 1));
  assign last_pixel = (row_reg == ROW_W'(HEIGHT - 1)) && (col_reg == COL_W'(WIDTH - 1));

  assign nbr_a = {sr_q[0][9:2], sr_q[1][9:2], sr_q[2][9:2], sr_q[CTR-1][9:2]};
  assign nbr_b = {sr_q[2*WIDTH+2][9:2], sr_q[2*WIDTH+1][9:2],
                  sr_q[2*WIDTH][9:2], sr_q[CTR+1][9:2]};

  nms_compare u_compare (
    .centre      (sr_q[CTR][9:2]),
    .neighbour_a (nbr_a),
    .neighbour_b (nbr_b),
    .direction   (sr_q[CTR][1:0]),
    .result      (cmp_result)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    col_next    = col_reg;
    row_next    = row_reg;
    result_next = result_reg;
    case (state_reg)
      PROLOGUE: begin
        if (shift) begin
          count_next = count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(WIDTH + 1)) state_next = NMS;
        end
      end
      NMS: begin
        // The pre-shift window is the one centred on (row, col).
        if (shift) begin
          result_next = border ? 8'd0 : cmp_result;
          state_next  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (!out_full) begin
          if (last_pixel) begin
            col_next   = '0;
            row_next   = '0;
            count_next = '0;
            state_next = PROLOGUE;
          end else begin
            state_next = NMS;
            if (col_reg == COL_W'(WIDTH - 1)) begin
              col_next = '0;
              row_next = row_reg + ROW_W'(1);
            end else begin
              col_next = col_reg + COL_W'(1);
            end
          end
        end
      end
      default: state_next = PROLOGUE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= PROLOGUE;
      count_reg  <= '0;
      col_reg    <= '0;
      row_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
      result_reg <= result_next;
    end
  end

  // Strobes are gated so they stay low for the whole time reset is held.
  assign in_rd_en  = pop && reset_n;
  assign out_wr_en = (state_reg == OUTPUT) && !out_full && reset_n;
  assign out_din   = result_reg;

endmodule

// File: tb/tb_non_max_suppression.sv
// Bench for non_max_suppression at 4x4: window vectors, flat frame, backpressure,
// mid-frame reset and random frames, all against a pixel-level image model.
`timescale 1ns/1ps
module tb_non_max_suppression;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       out_full = 1'b0;
  logic       in_rd_en, in_empty, out_wr_en;
  logic [9:0] in_dout;
  logic [7:0] out_din;

  always #5 clock = ~clock;

  non_max_suppression #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din)
  );

  // Upstream and downstream FIFO models.
  logic [9:0] src_mem [1024];
  int         src_wr = 0;
  int         src_rd = 0;
  logic       empty_force = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] cap [1024];
  int         cap_n = 0;

  assign in_empty = (src_rd == src_wr) || empty_force;
  assign in_dout  = src_mem[src_rd[9:0]];

  always @(posedge clock) begin
    if (flush) src_rd <= src_wr;
    else if (in_rd_en) src_rd <= src_rd + 1;
    if (out_wr_en) begin
      cap[cap_n[9:0]] <= out_din;
      cap_n <= cap_n + 1;
    end
  end

  // Image under test and its reference outputs.
  logic [7:0] img_mag [H][W];
  logic [1:0] img_dir [H][W];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [7:0] cen;
    logic [1:0] dir;
    logic [7:0] na;
    logic [7:0] nb;
    logic [7:0] exp_ge;
    logic [7:0] exp_gt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // First neighbour offset for a direction; the second is its mirror through the centre.
  function automatic void dir_off(input logic [1:0] d, output int dr, output int dc);
    case (d)
      2'd0:    begin dr = 0;  dc = -1; end
      2'd1:    begin dr = -1; dc = 1;  end
      2'd2:    begin dr = -1; dc = 0;  end
      default: begin dr = -1; dc = -1; end
    endcase
  endfunction

  function automatic logic [7:0] model_px(input int r, input int c);
    int dr, dc;
    logic [7:0] cen, a, b;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    dir_off(img_dir[r][c], dr, dc);
    cen = img_mag[r][c];
    a   = img_mag[r + dr][c + dc];
    b   = img_mag[r - dr][c - dc];
`ifdef NMS_STRICT_EN
    return (cen > a && cen > b) ? cen : 8'd0;
`else
    return (cen >= a && cen >= b) ? cen : 8'd0;
`endif
  endfunction

  function automatic int cap_at(input int i);
    return int'(cap[10'(i)]);
  endfunction

  task automatic load_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        src_mem[src_wr[9:0]] = {img_mag[r][c], img_dir[r][c]};
        src_wr++;
      end
  endtask

  task automatic rand_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[r][c] = ($urandom_range(0, 3) == 0) ? 8'd100 : 8'($urandom_range(0, 255));
        img_dir[r][c] = 2'($urandom_range(0, 3));
      end
  endtask

  task automatic vec_frame(input vec_t v);
    int dr, dc;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[r][c] = (r < 3 && c < 3) ? 8'd90 : 8'd0;
        img_dir[r][c] = 2'd0;
      end
    dir_off(v.dir, dr, dc);
    img_mag[1][1]           = v.cen;
    img_dir[1][1]           = v.dir;
    img_mag[1 + dr][1 + dc] = v.na;
    img_mag[1 - dr][1 - dc] = v.nb;
  endtask

  task automatic finish_frame(input string tag, input int base, input int rd0, input bit stall);
    int cyc = 0;
    while ((cap_n - base) < NPIX && cyc < 2000) begin
      @(negedge clock);
      if (stall) begin
        empty_force = ($urandom_range(0, 3) == 0);
        out_full    = ($urandom_range(0, 2) == 0);
      end
      cyc++;
    end
    empty_force = 1'b0;
    out_full    = 1'b0;
    repeat (6) @(negedge clock);
    $display("frame %s: pushes=%0d pops=%0d cycles=%0d", tag, cap_n - base, src_rd - rd0, cyc);
    check({tag, "_push_count"}, cap_n - base, NPIX);
    check({tag, "_pop_count"}, src_rd - rd0, NPIX);
    for (int i = 0; i < NPIX; i++)
      check($sformatf("%s_px%0d", tag, i), cap_at(base + i), int'(model_px(i / W, i % W)));
  endtask

  task automatic run_frame(input string tag, input bit stall, output int base);
    int rd0;
    base = cap_n;
    rd0  = src_rd;
    load_frame();
    finish_frame(tag, base, rd0, stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         base, rd0, cn0, rd_hold, cyc;
    logic [7:0] exp_v;

    vecs[0] = '{"ridge_h",      8'd80,  2'd0, 8'd90,  8'd10, 8'd0,   8'd0};
    vecs[1] = '{"ridge_v",      8'd80,  2'd2, 8'd20,  8'd20, 8'd80,  8'd80};
    vecs[2] = '{"tie_h",        8'd60,  2'd0, 8'd60,  8'd60, 8'd60,  8'd0};
    vecs[3] = '{"diag45_lose",  8'd40,  2'd1, 8'd30,  8'd41, 8'd0,   8'd0};
    vecs[4] = '{"diag135_tie",  8'd40,  2'd3, 8'd39,  8'd40, 8'd40,  8'd0};
    vecs[5] = '{"diag45_win",   8'd200, 2'd1, 8'd199, 8'd0,  8'd200, 8'd200};
    vecs[6] = '{"ridge_v_lose", 8'd80,  2'd2, 8'd81,  8'd20, 8'd0,   8'd0};

    // Reset with data waiting upstream: nothing may move.
    src_mem[0] = 10'h3ff;
    src_wr     = 1;
    repeat (3) @(negedge clock);
    check("rst_rd_en", int'(in_rd_en), 0);
    check("rst_wr_en", int'(out_wr_en), 0);
    check("rst_din", int'(out_din), 0);
    check("rst_no_pop", src_rd, 0);
    flush = 1'b1;
    @(negedge clock);
    flush   = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // Flat frame.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img_mag[r][c] = 8'd50;
        img_dir[r][c] = 2'd0;
      end
    run_frame("flat", 1'b0, base);
`ifdef NMS_STRICT_EN
    check("flat_interior", cap_at(base + 6), 0);
`else
    check("flat_interior", cap_at(base + 6), 50);
`endif
    check("flat_border", cap_at(base + 4), 0);

    // Window vectors around pixel (1,1).
    for (int i = 0; i < 7; i++) begin
      vec_frame(vecs[i]);
      run_frame(vecs[i].name, 1'(i % 2), base);
`ifdef NMS_STRICT_EN
      exp_v = vecs[i].exp_gt;
`else
      exp_v = vecs[i].exp_ge;
`endif
      check({vecs[i].name, "_centre"}, cap_at(base + 5), int'(exp_v));
    end

    // Backpressure while pixel (1,1) waits in OUTPUT with input available.
    rand_frame();
    img_mag[1][1] = 8'd255;
    img_dir[1][1] = 2'd0;
    img_mag[1][0] = 8'd10;
    img_mag[1][2] = 8'd20;
    base = cap_n;
    rd0  = src_rd;
    load_frame();
    cyc = 0;
    while ((cap_n - base) < 5 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    out_full = 1'b1;
    repeat (3) @(negedge clock);
    rd_hold = src_rd;
    cn0     = cap_n;
    check("bp_reached", cn0 - base, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("bp_wr_en", int'(out_wr_en), 0);
      check("bp_no_pop", src_rd, rd_hold);
      check("bp_no_push", cap_n, cn0);
      check("bp_din", int'(out_din), 255);
    end
    out_full = 1'b0;
    @(negedge clock);
    check("bp_release_push", cap_n - cn0, 1);
    check("bp_release_val", cap_at(cn0), 255);
    finish_frame("bp", base, rd0, 1'b0);

    // Random frames with upstream gaps and downstream stalls.
    for (int f = 0; f < 4; f++) begin
      rand_frame();
      run_frame($sformatf("rand%0d", f), 1'b1, base);
    end

    // Reset in the middle of a frame, then a clean frame.
    rand_frame();
    base = cap_n;
    load_frame();
    cyc = 0;
    while ((cap_n - base) < 7 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    reset_n = 1'b0;
    flush   = 1'b1;
    @(negedge clock);
    check("rst_mid_rd_en", int'(in_rd_en), 0);
    check("rst_mid_wr_en", int'(out_wr_en), 0);
    check("rst_mid_din", int'(out_din), 0);
    check("rst_mid_pushes", cap_n - base, 7);
    flush = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    rand_frame();
    run_frame("after_rst", 1'b1, base);
    rand_frame();
    run_frame("after_rst2", 1'b0, base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
